// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and default widths for the IFU/LSU memory port arbiter.
// Imported by the arbiter top and its grant-pick helper.
package mem_bus_arbiter_pkg;

    localparam int ARB_ADDR_W = 64;
    localparam int ARB_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_e;

    // Bits needed to count LSU grants from 0 up to and including the cap.
    function automatic int streak_width(input int streak_max);
        return $clog2(streak_max + 1);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_pick.sv
// Grant decision for one IDLE cycle: LSU priority, capped by the LSU streak
// counter so a waiting IFU is served after LSU_STREAK_MAX consecutive LSU grants.
module mem_arb_pick
    import mem_bus_arbiter_pkg::*;
#(
    parameter int LSU_STREAK_MAX = 4,
    parameter int STREAK_W       = streak_width(LSU_STREAK_MAX)
) (
    input  logic                ifu_req_valid,
    input  logic                lsu_req_valid,
    input  logic [STREAK_W-1:0] streak,
    output logic                grant_valid,
    output logic                grant_owner,
    output logic [STREAK_W-1:0] streak_next
);

    localparam logic [STREAK_W-1:0] STREAK_CAP = STREAK_W'(LSU_STREAK_MAX);

    logic lsu_wins;

    // NOTE: every output gets a default before the conditionals so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        lsu_wins    = lsu_req_valid && (!ifu_req_valid || (streak < STREAK_CAP));
        grant_valid = ifu_req_valid || lsu_req_valid;
        grant_owner = lsu_wins ? OWN_LSU : OWN_IFU;
        streak_next = streak;
        if (grant_valid) begin
            // LSU beating a waiting IFU implies streak < cap, so +1 cannot overflow.
            if (lsu_wins && ifu_req_valid) begin
                streak_next = streak + 1'b1;
            end else begin
                streak_next = '0;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-outstanding arbiter sharing the core memory port between IFU and LSU;
// routes each response back to the requester that issued the transaction.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W         = ARB_ADDR_W,
    parameter int DATA_W         = ARB_DATA_W,
    parameter int LSU_STREAK_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rsp_valid,
    input  logic                ifu_rsp_ready,
    output logic [DATA_W-1:0]   ifu_rdata,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_rsp_valid,
    input  logic                lsu_rsp_ready,
    output logic [DATA_W-1:0]   lsu_rdata,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    output logic                mem_rsp_ready,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int STREAK_W = streak_width(LSU_STREAK_MAX);

    arb_state_e          state_q, state_d;
    arb_owner_e          owner_q, owner_d;
    logic [STREAK_W-1:0] streak_q, streak_d;

    logic                grant_valid;
    logic                grant_owner;
    logic [STREAK_W-1:0] streak_next;

    logic in_issue;
    logic in_wait;
    logic own_lsu;
    logic owner_req_valid;
    logic owner_rsp_ready;

    mem_arb_pick #(
        .LSU_STREAK_MAX (LSU_STREAK_MAX),
        .STREAK_W       (STREAK_W)
    ) u_pick (
        .ifu_req_valid (ifu_req_valid),
        .lsu_req_valid (lsu_req_valid),
        .streak        (streak_q),
        .grant_valid   (grant_valid),
        .grant_owner   (grant_owner),
        .streak_next   (streak_next)
    );

    // Phase qualifiers are gated by rst_n so every handshake output is already
    // low during the reset cycle, before the synchronous reset takes effect.
    assign in_issue        = rst_n && (state_q == ISSUE);
    assign in_wait         = rst_n && (state_q == WAIT);
    assign own_lsu         = (owner_q == OWN_LSU);
    assign owner_req_valid = own_lsu ? lsu_req_valid : ifu_req_valid;
    assign owner_rsp_ready = own_lsu ? lsu_rsp_ready : ifu_rsp_ready;

    // Request side: only the owner sees the memory port, and only in ISSUE.
    assign mem_req_valid = in_issue && owner_req_valid;
    assign ifu_req_ready = in_issue && !own_lsu && mem_req_ready;
    assign lsu_req_ready = in_issue &&  own_lsu && mem_req_ready;

    assign mem_addr  = in_issue ? (own_lsu ? lsu_addr : ifu_addr) : '0;
    assign mem_wen   = in_issue && own_lsu && lsu_wen;
    assign mem_wdata = (in_issue && own_lsu) ? lsu_wdata : '0;
    assign mem_wmask = (in_issue && own_lsu) ? lsu_wmask : '0;

    // Response side: memory data reaches the owner only while waiting on it.
    assign mem_rsp_ready = in_wait && owner_rsp_ready;
    assign ifu_rsp_valid = in_wait && !own_lsu && mem_rsp_valid;
    assign lsu_rsp_valid = in_wait &&  own_lsu && mem_rsp_valid;
    assign ifu_rdata     = (in_wait && !own_lsu) ? mem_rdata : '0;
    assign lsu_rdata     = (in_wait &&  own_lsu) ? mem_rdata : '0;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        streak_d = streak_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d  = ISSUE;
                    owner_d  = arb_owner_e'(grant_owner);
                    streak_d = streak_next;
                end
            end
            ISSUE: begin
                if (mem_req_valid && mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Returning to IDLE first means a request arriving now waits a cycle.
                if (mem_rsp_valid && mem_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= OWN_IFU;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            streak_q <= streak_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized checks of mem_bus_arbiter against a transaction-level
// model of the LSU-priority / streak-capped arbitration rules.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int MW = DW / 8;
    localparam int STREAK_MAX = 4;
    localparam logic [DW-1:0] SALT = 64'hA5A5_5A5A_0F0F_F0F0;
    // Grant order (1 = LSU) under continuous dual requests, bit i = grant i.
    localparam logic [5:0] ORDER_MAX4 = 6'b101111;
    localparam logic [5:0] ORDER_MAX1 = 6'b010101;
    localparam int STREAK_SEQ [6] = '{1, 2, 3, 4, 0, 1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          ifu_req_valid, ifu_rsp_ready, lsu_req_valid, lsu_wen, lsu_rsp_ready;
    logic [AW-1:0] ifu_addr, lsu_addr;
    logic [DW-1:0] lsu_wdata, mem_rdata;
    logic [MW-1:0] lsu_wmask;
    logic          mem_req_ready, mem_rsp_valid;

    logic          ifu_req_ready, ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid;
    logic [DW-1:0] ifu_rdata, lsu_rdata, mem_wdata;
    logic          mem_req_valid, mem_wen, mem_rsp_ready;
    logic [AW-1:0] mem_addr;
    logic [MW-1:0] mem_wmask;

    logic          d1_ifu_req_ready, d1_ifu_rsp_valid, d1_lsu_req_ready, d1_lsu_rsp_valid;
    logic [DW-1:0] d1_ifu_rdata, d1_lsu_rdata, d1_mem_wdata;
    logic          d1_mem_req_valid, d1_mem_wen, d1_mem_rsp_ready;
    logic [AW-1:0] d1_mem_addr;
    logic [MW-1:0] d1_mem_wmask;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LSU_STREAK_MAX(STREAK_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rdata(mem_rdata)
    );

    // Strict-alternation variant driven by the same stimulus.
    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LSU_STREAK_MAX(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(d1_ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(d1_ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rdata(d1_ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(d1_lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(d1_lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rdata(d1_lsu_rdata),
        .mem_req_valid(d1_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(d1_mem_addr),
        .mem_wen(d1_mem_wen), .mem_wdata(d1_mem_wdata), .mem_wmask(d1_mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(d1_mem_rsp_ready), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit            got [6];
        bit            got1 [6];
        int            stk [6];
        int            n, n1, rsp_cnt, n_txn;
        bit            ifu_acc, lsu_acc, req_hs, rsp_hs, mem_pend, m_busy, m_issued, m_lsu;
        int            mem_dly, m_streak;
        logic [AW-1:0] pend_addr, hs_addr;

        ifu_req_valid = 0; ifu_addr = '0; ifu_rsp_ready = 0;
        lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
        lsu_rsp_ready = 0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = '0;

        // ---------------- reset state ----------------
        repeat (3) cyc();
        check("rst_state", dut.state_q, IDLE);
        check("rst_owner", dut.owner_q, OWN_IFU);
        check("rst_streak", dut.streak_q, 0);
        check("rst_valids", {mem_req_valid, ifu_req_ready, lsu_req_ready, mem_rsp_ready,
                             ifu_rsp_valid, lsu_rsp_valid}, 0);
        check("rst_payload", {mem_addr ^ 64'h0, 55'h0, mem_wen, mem_wmask} != 0, 0);
        rst_n = 1;

        // ---------------- IFU-only read ----------------
        cyc();
        ifu_req_valid = 1; ifu_addr = 64'h8000_0000; mem_req_ready = 1; ifu_rsp_ready = 1;
        #1;
        check("ifu_idle_ready", ifu_req_ready, 0);
        check("ifu_idle_memv", mem_req_valid, 0);
        cyc(); #1;
        check("ifu_req_ready", ifu_req_ready, 1);
        check("ifu_mem_valid", mem_req_valid, 1);
        check("ifu_mem_addr", mem_addr, 64'h8000_0000);
        check("ifu_mem_wen_mask", {mem_wen, mem_wmask}, 0);
        check("ifu_lsu_ready", lsu_req_ready, 0);
        cyc();
        ifu_req_valid = 0; mem_rsp_valid = 1; mem_rdata = 64'h0000_0013_0000_0297;
        #1;
        check("ifu_rsp_valid", ifu_rsp_valid, 1);
        check("ifu_rdata", ifu_rdata, 64'h0000_0013_0000_0297);
        check("ifu_lsu_rsp", lsu_rsp_valid, 0);
        check("ifu_mem_rsp_ready", mem_rsp_ready, 1);
        check("ifu_wait_req_ready", ifu_req_ready, 0);
        cyc();
        mem_rsp_valid = 0;
        #1;
        check("ifu_back_idle", dut.state_q, IDLE);
        check("ifu_rsp_done", {ifu_rsp_valid, ifu_rdata != 0}, 0);

        // ---------------- LSU store ----------------
        cyc();
        lsu_req_valid = 1; lsu_addr = 64'h8000_1000; lsu_wen = 1;
        lsu_wdata = 64'hDEADBEEF_CAFEF00D; lsu_wmask = 8'h0F; lsu_rsp_ready = 1;
        #1;
        check("st_idle_ready", {ifu_req_ready, lsu_req_ready}, 0);
        cyc(); #1;
        check("st_mem_valid", mem_req_valid, 1);
        check("st_mem_wen", mem_wen, 1);
        check("st_mem_addr", mem_addr, 64'h8000_1000);
        check("st_mem_wdata", mem_wdata, 64'hDEADBEEF_CAFEF00D);
        check("st_mem_wmask", mem_wmask, 8'h0F);
        check("st_ready", {ifu_req_ready, lsu_req_ready}, 2'b01);
        cyc();
        lsu_req_valid = 0; mem_rsp_valid = 1;
        #1;
        check("st_rsp_valid", lsu_rsp_valid, 1);
        check("st_ifu_quiet", {ifu_req_ready, ifu_rsp_valid}, 0);
        cyc();
        mem_rsp_valid = 0;
        #1;
        check("st_rsp_pulse", lsu_rsp_valid, 0);
        check("st_back_idle", dut.state_q, IDLE);
        check("st_streak", dut.streak_q, 0);

        // ---------------- continuous dual requests: streak cap ----------------
        cyc();
        ifu_addr = 64'h8000_0100; lsu_addr = 64'h8000_2000; lsu_wen = 0;
        ifu_req_valid = 1; lsu_req_valid = 1; mem_req_ready = 1; mem_rsp_valid = 1;
        mem_rdata = 64'h1234; ifu_rsp_ready = 1; lsu_rsp_ready = 1;
        n = 0; n1 = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (n < 6 && mem_req_valid && mem_req_ready) begin
                got[n] = lsu_req_ready;
                stk[n] = int'(dut.streak_q);
                n++;
            end
            if (n1 < 6 && d1_mem_req_valid && mem_req_ready) begin
                got1[n1] = d1_lsu_req_ready;
                n1++;
            end
            if (n >= 6) break;
            cyc();
        end
        check("pri_grant_count", n, 6);
        check("alt_grant_count", n1, 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("pri_order[%0d]", i), got[i], ORDER_MAX4[i]);
            check($sformatf("pri_streak[%0d]", i), stk[i], STREAK_SEQ[i]);
            check($sformatf("alt_order[%0d]", i), got1[i], ORDER_MAX1[i]);
        end
        cyc();
        ifu_req_valid = 0; lsu_req_valid = 0;
        cyc();
        mem_rsp_valid = 0;
        #1;
        check("pri_back_idle", {dut.state_q, dut1.state_q}, {IDLE, IDLE});

        // ---------------- backpressure on both sides ----------------
        cyc();
        lsu_req_valid = 1; lsu_addr = 64'h8000_3008; lsu_wen = 0; lsu_wdata = 64'h1111;
        lsu_wmask = 8'hFF; mem_req_ready = 0; lsu_rsp_ready = 0;
        mem_rsp_valid = 1; mem_rdata = 64'h77;
        #1;
        check("stray_idle", {mem_rsp_ready, lsu_rsp_valid, ifu_rsp_valid}, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(); #1;
            check("bp_req_valid", mem_req_valid, 1);
            check("bp_payload", mem_addr, 64'h8000_3008);
            check("bp_wdata", mem_wdata, 64'h1111);
            check("bp_ready_low", lsu_req_ready, 0);
            check("stray_issue", {mem_rsp_ready, lsu_rsp_valid, ifu_rsp_valid}, 0);
        end
        cyc();
        mem_req_ready = 1; mem_rsp_valid = 0;
        #1;
        check("bp_accept", lsu_req_ready, 1);
        check("bp_accept_addr", mem_addr, 64'h8000_3008);
        cyc();
        lsu_req_valid = 0; mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 64'hFEED_0000_0000_BEEF;
        rsp_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_rsp_valid", lsu_rsp_valid, 1);
            check("bp_rsp_data", lsu_rdata, 64'hFEED_0000_0000_BEEF);
            check("bp_rsp_ready_low", mem_rsp_ready, 0);
            if (mem_rsp_valid && mem_rsp_ready) rsp_cnt++;
            cyc();
        end
        lsu_rsp_ready = 1;
        #1;
        check("bp_rsp_ready", mem_rsp_ready, 1);
        if (mem_rsp_valid && mem_rsp_ready) rsp_cnt++;
        cyc(); #1;
        check("bp_back_idle", dut.state_q, IDLE);
        check("bp_idle_rsp", {mem_rsp_ready, lsu_rsp_valid}, 0);
        if (mem_rsp_valid && mem_rsp_ready) rsp_cnt++;
        check("bp_one_rsp_hs", rsp_cnt, 1);
        mem_rsp_valid = 0;

        // ---------------- reset during WAIT ----------------
        cyc();
        ifu_req_valid = 1; ifu_addr = 64'h8000_0040; mem_req_ready = 1; ifu_rsp_ready = 1;
        cyc();
        cyc();
        ifu_req_valid = 0; rst_n = 0;
        #1;
        check("rw_in_wait", dut.state_q, WAIT);
        check("rw_gated", {mem_req_valid, ifu_req_ready, lsu_req_ready, mem_rsp_ready,
                           ifu_rsp_valid, lsu_rsp_valid}, 0);
        cyc(); #1;
        check("rw_idle", dut.state_q, IDLE);
        check("rw_valids", {mem_req_valid, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid}, 0);
        rst_n = 1; mem_rsp_valid = 1; mem_rdata = 64'hBAD0_BAD0;
        #1;
        check("rw_late_rsp", {ifu_rsp_valid, mem_rsp_ready, ifu_rdata != 0}, 0);
        cyc();
        mem_rsp_valid = 0; lsu_req_valid = 1; lsu_addr = 64'h8000_4000; lsu_wen = 0;
        lsu_rsp_ready = 1;
        cyc(); #1;
        check("rw_lsu_ready", lsu_req_ready, 1);
        check("rw_lsu_addr", mem_addr, 64'h8000_4000);
        cyc();
        lsu_req_valid = 0; mem_rsp_valid = 1; mem_rdata = 64'h0BAD_F00D;
        #1;
        check("rw_lsu_rsp", lsu_rsp_valid, 1);
        check("rw_lsu_rdata", lsu_rdata, 64'h0BAD_F00D);
        cyc();
        mem_rsp_valid = 0;
        #1;
        check("rw_lsu_done", dut.state_q, IDLE);

        // ---------------- randomized traffic vs transaction model ----------------
        ifu_acc = 0; lsu_acc = 0; req_hs = 0; rsp_hs = 0; mem_pend = 0; mem_dly = 0;
        m_busy = 0; m_issued = 0; m_lsu = 0; m_streak = 0; n_txn = 0;
        pend_addr = '0; hs_addr = '0;
        for (int k = 0; k < 3000; k++) begin
            if (ifu_acc) ifu_req_valid = 0;
            if (lsu_acc) lsu_req_valid = 0;
            if (!ifu_req_valid && $urandom_range(0, 2) == 0) begin
                ifu_req_valid = 1;
                ifu_addr = {$urandom(), $urandom()};
            end
            if (!lsu_req_valid && $urandom_range(0, 2) == 0) begin
                lsu_req_valid = 1;
                lsu_addr  = {$urandom(), $urandom()};
                lsu_wen   = 1'($urandom_range(0, 1));
                lsu_wdata = {$urandom(), $urandom()};
                lsu_wmask = 8'($urandom_range(0, 255));
            end
            ifu_rsp_ready = ($urandom_range(0, 3) != 0);
            lsu_rsp_ready = ($urandom_range(0, 3) != 0);
            mem_req_ready = ($urandom_range(0, 2) != 0);
            if (rsp_hs) mem_pend = 0;
            if (req_hs) begin
                mem_pend = 1;
                mem_dly = $urandom_range(0, 3);
                pend_addr = hs_addr;
            end else if (mem_pend && mem_dly > 0) begin
                mem_dly--;
            end
            if (mem_pend) mem_rsp_valid = (mem_dly == 0);
            else          mem_rsp_valid = ($urandom_range(0, 7) == 0);
            mem_rdata = (mem_pend && mem_dly == 0) ? (pend_addr ^ SALT) : {$urandom(), $urandom()};

            @(negedge clk);
            ifu_acc = ifu_req_valid && ifu_req_ready;
            lsu_acc = lsu_req_valid && lsu_req_ready;
            req_hs  = mem_req_valid && mem_req_ready;
            rsp_hs  = mem_rsp_valid && mem_rsp_ready;
            hs_addr = mem_addr;
            if (!m_busy) check("r_idle_req", mem_req_valid, 0);
            if (!(m_busy && m_issued))
                check("r_no_rsp", {ifu_rsp_valid, lsu_rsp_valid, mem_rsp_ready}, 0);
            if (m_busy && !m_issued) begin
                check("r_owner_hold", m_lsu ? lsu_req_valid : ifu_req_valid, 1);
                check("r_streak", dut.streak_q, m_streak);
                check("r_req_ready", {ifu_req_ready, lsu_req_ready},
                      m_lsu ? {1'b0, mem_req_ready} : {mem_req_ready, 1'b0});
            end
            if (req_hs) begin
                check("r_req_phase", m_busy && !m_issued, 1);
                check("r_addr", mem_addr, m_lsu ? lsu_addr : ifu_addr);
                check("r_wen", mem_wen, m_lsu ? lsu_wen : 1'b0);
                check("r_wmask", mem_wmask, m_lsu ? lsu_wmask : 8'h00);
                if (m_lsu) check("r_wdata", mem_wdata, lsu_wdata);
                m_issued = 1;
            end
            if (rsp_hs) begin
                check("r_rsp_phase", m_busy && m_issued, 1);
                check("r_rsp_route", {ifu_rsp_valid, lsu_rsp_valid}, m_lsu ? 2'b01 : 2'b10);
                check("r_rdata", m_lsu ? lsu_rdata : ifu_rdata, mem_rdata);
                check("r_rdata_other", m_lsu ? ifu_rdata : lsu_rdata, 0);
            end
            // One transaction at a time; a free port grants on the next edge.
            if (!m_busy) begin
                if (ifu_req_valid || lsu_req_valid) begin
                    if (lsu_req_valid && (!ifu_req_valid || m_streak < STREAK_MAX)) begin
                        m_lsu = 1;
                        m_streak = ifu_req_valid ? ((m_streak < STREAK_MAX) ? m_streak + 1 : STREAK_MAX) : 0;
                    end else begin
                        m_lsu = 0;
                        m_streak = 0;
                    end
                    m_busy = 1;
                end
            end else if (rsp_hs && m_issued) begin
                m_busy = 0;
                m_issued = 0;
                n_txn++;
            end
            @(posedge clk);
            #1;
        end
        check("r_progress", n_txn >= 100, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
